// File: rtl/uart_frame_parser_if.sv
// Payload byte stream leaving the frame parser.
// valid/ready: a byte transfers on any clock edge where valid && ready; data/last hold while valid && !ready.
interface uart_frame_parser_if;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/uart_frame_parser.sv
// Frame parser: SOF0 SOF1 LEN PAYLOAD[LEN] CHK from the RX FIFO, payload streamed out.
// Optional inter-byte timeout enabled by defining UART_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] SOF0           = 8'h55,
  parameter logic [7:0] SOF1           = 8'hAA
) (
  input  logic                        i_sys_clk,
  input  logic                        i_sys_rst_n,
  input  logic                        i_fifo_empty,
  input  logic [7:0]                  i_fifo_rdata,
  output logic                        o_fifo_rden,
  uart_frame_parser_if.master         pay,
  output logic                        o_frame_done,
  output logic                        o_frame_ok,
  output logic [1:0]                  o_err_code,
  output logic [15:0]                 o_frame_cnt,
  output logic [2:0]                  o_dbg_state
);

  typedef enum logic [2:0] {
    ST_HUNT0   = 3'd0,
    ST_HUNT1   = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t      state_q, state_d;
  logic        rd_pend;
  logic        byte_rx;
  logic [7:0]  rx;
  logic [7:0]  len_q, cnt_q, sum_q;
  logic [7:0]  data_q;
  logic        valid_q, last_q;
  logic        is_last;
  logic        done_set, ok_set, len_load, pay_load;
  logic [1:0]  err_set;
  logic        tmo_hit;

  // One read in flight at a time, and none while a payload byte waits downstream.
  assign o_fifo_rden = !i_fifo_empty && !rd_pend && !valid_q;
  assign byte_rx     = rd_pend;
  assign rx          = i_fifo_rdata;
  assign is_last     = (cnt_q == len_q - 8'd1);

  assign pay.data    = data_q;
  assign pay.valid   = valid_q;
  assign pay.last    = last_q;
  assign o_dbg_state = state_q;

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_run;

  // Downstream stalls are not the sender's fault, so they do not age the frame.
  assign tmo_run = (state_q != ST_HUNT0) && !(valid_q && !pay.ready);
  assign tmo_hit = tmo_run && !byte_rx && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n)                        tmo_q <= '0;
    else if (byte_rx || state_q == ST_HUNT0) tmo_q <= '0;
    else if (tmo_run)                        tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) state_q <= ST_HUNT0;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    ok_set   = 1'b0;
    err_set  = 2'd0;
    len_load = 1'b0;
    pay_load = 1'b0;
    if (byte_rx) begin
      case (state_q)
        ST_HUNT0: if (rx == SOF0) state_d = ST_HUNT1;
        ST_HUNT1: begin
          if (rx == SOF1)      state_d = ST_LEN;
          else if (rx == SOF0) state_d = ST_HUNT1;
          else                 state_d = ST_HUNT0;
        end
        ST_LEN: begin
          if (rx == 8'd0 || rx > MAX_LEN_B) begin
            done_set = 1'b1;
            err_set  = 2'd1;
            state_d  = ST_HUNT0;
          end else begin
            len_load = 1'b1;
            state_d  = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pay_load = 1'b1;
          if (is_last) state_d = ST_CHK;
        end
        ST_CHK: begin
          done_set = 1'b1;
          state_d  = ST_HUNT0;
          if (rx == sum_q) ok_set  = 1'b1;
          else             err_set = 2'd2;
        end
        default: state_d = ST_HUNT0;
      endcase
    end else if (tmo_hit) begin
      done_set = 1'b1;
      err_set  = 2'd3;
      state_d  = ST_HUNT0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      rd_pend      <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_err_code   <= '0;
      o_frame_cnt  <= '0;
    end else begin
      rd_pend      <= o_fifo_rden;
      o_frame_done <= done_set;
      if (len_load) begin
        len_q <= rx;
        sum_q <= rx;
        cnt_q <= '0;
      end
      // The read rule keeps a new payload byte from landing on an unaccepted one.
      if (pay_load) begin
        data_q  <= rx;
        last_q  <= is_last;
        valid_q <= 1'b1;
        sum_q   <= sum_q + rx;
        cnt_q   <= cnt_q + 8'd1;
      end else if (valid_q && pay.ready) begin
        valid_q <= 1'b0;
      end
      if (done_set) begin
        o_frame_ok <= ok_set;
        o_err_code <= err_set;
      end
      if (ok_set) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: FIFO model, payload/done monitors, scenario tasks.
module tb_uart_frame_parser;
`ifdef UART_PARSER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 50000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_rden;
  logic        frame_done, frame_ok;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  bit         take = 1'b0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic [2:0] done_q[$];

  uart_frame_parser_if pay_if();

  uart_frame_parser #(.MAX_LEN(64), .TIMEOUT_CYCLES(TMO)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .i_fifo_empty(fifo_empty),
    .i_fifo_rdata(fifo_rdata),
    .o_fifo_rden (fifo_rden),
    .pay         (pay_if),
    .o_frame_done(frame_done),
    .o_frame_ok  (frame_ok),
    .o_err_code  (err_code),
    .o_frame_cnt (frame_cnt),
    .o_dbg_state (dbg_state)
  );

  always #10 clk = ~clk;

  // FIFO read port: data for a read accepted on edge N is presented before edge N+1.
  always @(negedge clk) begin
    if (take) begin
      fifo_rdata = fifo_q.pop_front();
      take = 1'b0;
    end
    if (fifo_rden) take = 1'b1;
    fifo_empty = (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (pay_if.valid && pay_if.ready) got_q.push_back({pay_if.last, pay_if.data});
    if (frame_done) done_q.push_back({frame_ok, err_code});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    repeat (5) step();
    got_q.delete();
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic wait_done(input int n, input string name);
    int k = 0;
    while (done_q.size() < n && k < 400) begin
      step();
      k++;
    end
    repeat (3) step();
    checks++;
    if (done_q.size() != n) begin
      errors++;
      $display("FAIL %s done_count got=%0d required=%0d", name, done_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pay_if.ready = 1'b1;
    repeat (3) step();
    checks++;
    if ({pay_if.valid, pay_if.last, pay_if.data} !== 10'd0) begin
      errors++;
      $display("FAIL reset_stream got=%h required=0", {pay_if.valid, pay_if.last, pay_if.data});
    end
    checks++;
    if ({frame_done, frame_ok, err_code, frame_cnt} !== 20'd0) begin
      errors++;
      $display("FAIL reset_status got=%h required=0", {frame_done, frame_ok, err_code, frame_cnt});
    end
    checks++;
    if (fifo_rden !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctrl rden=%b state=%0d required rden=0 state=0", fifo_rden, dbg_state);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_good_frame();
    logic [7:0] v[7] = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    clear_logs();
    foreach (v[i]) fifo_q.push_back(v[i]);
    exp_q = '{9'h011, 9'h022, 9'h133};
    wait_done(1, "good");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL good_len got=%0d required=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL good_byte%0d got=%h required=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (done_q.size() > 0 && done_q[0] !== 3'b100) begin
      errors++;
      $display("FAIL good_status got=%b required=100", done_q[0]);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL good_cnt got=%0d required=1", frame_cnt);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] v[7] = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    clear_logs();
    foreach (v[i]) fifo_q.push_back(v[i]);
    wait_done(1, "badchk");
    checks++;
    if (got_q.size() != 3 || (got_q.size() == 3 && got_q[2] !== 9'h133)) begin
      errors++;
      $display("FAIL badchk_payload got_n=%0d required_n=3 last_word=133", got_q.size());
    end
    checks++;
    if (done_q.size() > 0 && done_q[0] !== 3'b010) begin
      errors++;
      $display("FAIL badchk_status got=%b required=010", done_q[0]);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL badchk_cnt got=%0d required=1", frame_cnt);
    end
  endtask

  task automatic test_bad_len();
    logic [7:0] v[6] = '{8'h55, 8'hAA, 8'h00, 8'h55, 8'hAA, 8'h41};
    clear_logs();
    foreach (v[i]) fifo_q.push_back(v[i]);
    wait_done(2, "badlen");
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done_q.size() > i && done_q[i] !== 3'b001) begin
        errors++;
        $display("FAIL badlen_status%0d got=%b required=001", i, done_q[i]);
      end
    end
    checks++;
    if (got_q.size() != 0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL badlen_idle payload_n=%0d state=%0d required 0/0", got_q.size(), dbg_state);
    end
  endtask

  task automatic test_resync();
    logic [7:0] v[7] = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80};
    clear_logs();
    foreach (v[i]) fifo_q.push_back(v[i]);
    wait_done(1, "resync");
    checks++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== 9'h17F)) begin
      errors++;
      $display("FAIL resync_payload got_n=%0d required one word 17F", got_q.size());
    end
    checks++;
    if ((done_q.size() > 0 && done_q[0] !== 3'b100) || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL resync_status cnt=%0d required ok=1 err=0 cnt=2", frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] v[7] = '{8'h55, 8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    int k = 0;
    int bad = 0;
    clear_logs();
    pay_if.ready = 1'b0;
    foreach (v[i]) fifo_q.push_back(v[i]);
    while (!pay_if.valid && k < 100) begin
      step();
      k++;
    end
    checks++;
    if (!pay_if.valid) begin
      errors++;
      $display("FAIL bp_first_valid got=0 required=1");
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (pay_if.data !== 8'h01 || pay_if.valid !== 1'b1 || pay_if.last !== 1'b0 || fifo_rden !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL bp_hold cyc=%0d data=%h valid=%b rden=%b required data=01 valid=1 rden=0",
                   c, pay_if.data, pay_if.valid, fifo_rden);
      end
      step();
    end
    pay_if.ready = 1'b1;
    exp_q = '{9'h001, 9'h002, 9'h103};
    wait_done(1, "bp");
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL bp_len got=%0d required=3", got_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_byte%0d got=%h required=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ((done_q.size() > 0 && done_q[0] !== 3'b100) || frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL bp_status cnt=%0d required ok=1 err=0 cnt=3", frame_cnt);
    end
  endtask

`ifdef UART_PARSER_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] v[4] = '{8'h55, 8'hAA, 8'h02, 8'h11};
    int k = 0;
    int t0;
    clear_logs();
    foreach (v[i]) fifo_q.push_back(v[i]);
    while (got_q.size() == 0 && k < 100) begin
      step();
      k++;
    end
    t0 = k;
    while (done_q.size() == 0 && k < 400) begin
      step();
      k++;
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] !== 3'b011) begin
      errors++;
      $display("FAIL timeout_status n=%0d required one done ok=0 err=3", done_q.size());
    end
    checks++;
    if (k - t0 < 95 || k - t0 > 110) begin
      errors++;
      $display("FAIL timeout_delay got=%0d required=95..110", k - t0);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [7:0] v[4] = '{8'h55, 8'hAA, 8'h02, 8'h11};
    int k = 0;
    clear_logs();
    foreach (v[i]) fifo_q.push_back(v[i]);
    while (got_q.size() == 0 && k < 100) begin
      step();
      k++;
    end
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pay_if.valid, pay_if.data, frame_done, frame_ok, err_code, frame_cnt, dbg_state} !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs got=%h required=0",
               {pay_if.valid, pay_if.data, frame_done, frame_ok, err_code, frame_cnt, dbg_state});
    end
    step();
    rst_n = 1'b1;
    repeat (30) step();
    checks++;
    if (done_q.size() != 0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL midreset_nodone done_n=%0d state=%0d required 0/0", done_q.size(), dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_len();
    test_resync();
    test_backpressure();
`ifdef UART_PARSER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
